keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
Sequences the 4x4 keypad matrix scan that feeds the keypad debouncer. The block drives one column low at a time and samples the synchronized active-low rows on a prescaled tick. When it detects a key, it freezes the scan on that column, presents an 8-bit key code and holds a level key_pressed until release. The debouncer consumes key_code/key_pressed; the scan rate set here is the rate the debouncer's counter runs against.

Parameters:
CLK_DIV, 60000, system clocks per scan tick (48 MHz / 60000 = 800 Hz tick); must be >= 2
RELEASE_TICKS, 2, consecutive all-rows-high ticks in HOLD required to declare release; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
rows_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
cols_n  output  4  column drive, one-hot active-low
key_code  output  8  [7:4] row one-hot active-high, [3:0] column one-hot active-high
key_pressed  output  1  level, high while a key is held (to debouncer key_pressed)
scan_tick  output  1  one-clk pulse per prescaler wrap (exported for debug/debouncer timing)

Behaviour:
- Reset (clk edge with reset=0): state SCAN, col_idx 0, cols_n 4'b1110, key_code 8'h00, key_pressed 0, scan_tick 0, prescaler 0, release_cnt 0, synchronizer flops 4'hF.
- Synchronizer: rows_n passes through a 2-flop synchronizer to give rows_s. All decisions use rows_s only.
- Prescaler: counts 0..CLK_DIV-1 and wraps to 0. scan_tick is registered and high for exactly the one clk after count==CLK_DIV-1. The prescaler runs continuously in every state.
- cols_n is always the registered ~(1<<col_idx). It changes only on tick processing, so each column is held for a full tick period before it is sampled.
- SCAN, on a tick:
  - If any rows_s bit is 0: go to HOLD. Latch key_code = {row_onehot, 1<<col_idx}. Set key_pressed=1. Hold col_idx. release_cnt=0.
  - If rows_s is 4'hF: col_idx increments 0->1->2->3->0.
  - No action between ticks.
- Multiple rows low in SCAN: the lowest row index wins (priority encode). Example: rows_s=1001 selects row 1, giving row_onehot 0010.
- HOLD, on a tick:
  - If rows_s==4'hF: release_cnt increments. When it reaches RELEASE_TICKS, clear key_pressed, advance col_idx, return to SCAN, and clear release_cnt.
  - If any row is low: release_cnt=0 and stay in HOLD.
- HOLD keeps key_code constant. It ignores new rows in the same column and cannot see other columns because the column is frozen.
- key_code retains its last value after release, until the next detection.
- Latency: a row edge on rows_n reaches rows_s in 2 clks. It is acted on at the next tick. key_pressed and key_code update in the same clk as the state change, one clk after the tick is processed.
- Reset asserted mid-HOLD or mid-scan: all state and outputs return to reset values on that edge. No pending release is reported.
- FSM encoding is a 2-state enum {SCAN, HOLD}. An illegal encoding recovers to SCAN.

Optional Feature:
Macro: KEYPAD_GHOST_REJECT_EN
- Defined: in SCAN, a tick with more than one rows_s bit low is treated as no press. The column advances and key_pressed stays 0. This rejects multi-key/ghost patterns.
- Undefined: the lowest-index-row priority rule above applies.
- HOLD behaviour is identical in both builds.

Test Plan:
The bench models rows_n combinationally from cols_n, with CLK_DIV=4 and RELEASE_TICKS=2.
- Reset then idle keypad (rows_n=4'hF): cols_n=1110, key_code=00, key_pressed=0. cols_n then steps 1110->1101->1011->0111->1110, one step per scan_tick, and scan_tick pulses every 4 clks.
- Press row2/col1 (rows_n=1011 only while cols_n==1101): key_pressed rises, key_code=8'b0100_0010, and cols_n stays at 1101 for 10+ ticks while held.
- Release: rows_n high for 2 ticks, then key_pressed falls, cols_n advances to 1011, and key_code stays 0100_0010. A bounce (high 1 tick, low 1 tick, high 2 ticks) keeps key_pressed=1 until the final 2 high ticks.
- Two keys in col0 (rows_n=1001 while cols_n==1110): default build gives key_code=0010_0001 and key_pressed=1. With KEYPAD_GHOST_REJECT_EN, key_pressed stays 0 and cols_n advances to 1101.
- reset=0 for one edge during HOLD: next clk shows cols_n=1110, key_pressed=0, key_code=00. Scanning resumes after reset deasserts.
- Row pulse shorter than the 2-flop sync path plus the time to the next tick: no detection.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad matrix scanner: walks one active-low column per scan tick, freezes on a detected key
// and holds key_pressed until release. Optional build macro: KEYPAD_GHOST_REJECT_EN.
module keypad_scan_ctrl #(
  parameter int CLK_DIV       = 60000,
  parameter int RELEASE_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       scan_tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = $clog2(RELEASE_TICKS + 1);

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state, state_d;
  logic [3:0]      rows_meta, rows_s;
  logic [PW-1:0]   presc;
  logic [1:0]      col_idx, col_idx_d;
  logic [RW-1:0]   release_cnt, release_cnt_d;
  logic [7:0]      key_code_d;
  logic            key_pressed_d;
  logic [3:0]      row_onehot;
  logic            press_seen;

  // rows_n is asynchronous to clk; only rows_s is ever used for decisions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rows_meta <= 4'hF;
      rows_s    <= 4'hF;
    end else begin
      rows_meta <= rows_n;
      rows_s    <= rows_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc     <= '0;
      scan_tick <= 1'b0;
    end else begin
      if (presc == PW'(CLK_DIV - 1)) presc <= '0;
      else                           presc <= presc + 1'b1;
      scan_tick <= (presc == PW'(CLK_DIV - 1));
    end
  end

  // Lowest row index wins when several rows are low.
  always_comb begin
    row_onehot = 4'b0000;
    if      (!rows_s[0]) row_onehot = 4'b0001;
    else if (!rows_s[1]) row_onehot = 4'b0010;
    else if (!rows_s[2]) row_onehot = 4'b0100;
    else if (!rows_s[3]) row_onehot = 4'b1000;
  end

`ifdef KEYPAD_GHOST_REJECT_EN
  assign press_seen = ($countones(~rows_s) == 1);
`else
  assign press_seen = (rows_s != 4'hF);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      release_cnt <= '0;
      key_code    <= 8'h00;
      key_pressed <= 1'b0;
      cols_n      <= 4'b1110;
    end else begin
      state       <= state_d;
      col_idx     <= col_idx_d;
      release_cnt <= release_cnt_d;
      key_code    <= key_code_d;
      key_pressed <= key_pressed_d;
      cols_n      <= ~(4'b0001 << col_idx_d);
    end
  end

  always_comb begin
    state_d       = state;
    col_idx_d     = col_idx;
    release_cnt_d = release_cnt;
    key_code_d    = key_code;
    key_pressed_d = key_pressed;
    case (state)
      SCAN: begin
        if (scan_tick) begin
          if (press_seen) begin
            state_d       = HOLD;
            key_code_d    = {row_onehot, 4'b0001 << col_idx};
            key_pressed_d = 1'b1;
            release_cnt_d = '0;
          end else begin
            col_idx_d = col_idx + 2'd1;
          end
        end
      end
      HOLD: begin
        // The column stays frozen, so only the held key's column is visible here.
        if (scan_tick) begin
          if (rows_s == 4'hF) begin
            if (release_cnt == RW'(RELEASE_TICKS - 1)) begin
              state_d       = SCAN;
              key_pressed_d = 1'b0;
              col_idx_d     = col_idx + 2'd1;
              release_cnt_d = '0;
            end else begin
              release_cnt_d = release_cnt + 1'b1;
            end
          end else begin
            release_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d       = SCAN;
        col_idx_d     = 2'd0;
        release_cnt_d = '0;
        key_pressed_d = 1'b0;
      end
    endcase
  end

endmodule
